// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions.
// Contents:
//   UART_FIFO_DEPTH_DEFAULT   - default receive FIFO depth (entries)
//   UART_FIFO_THRESH_DEFAULT  - default level threshold for thresh_flag
//   UART_TIMEOUT_BITS_DEFAULT - default idle bit-times before timeout_flag
//   byte_t                    - one UART data byte
package uart_pkg;

    localparam int UART_FIFO_DEPTH_DEFAULT   = 16;
    localparam int UART_FIFO_THRESH_DEFAULT  = 8;
    localparam int UART_TIMEOUT_BITS_DEFAULT = 40;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Handshake/status bundle between the UART receiver core plus bus slave
// (master side) and the receive FIFO (slave side).
// Signals:
//   rx_data, rx_done   - byte and one-cycle push strobe from the receiver core
//   bit_period         - clocks per bit, used only by the idle timeout
//   pop, flush         - consume head byte / discard all contents
//   clr_overrun        - clear the sticky overrun flag
//   rd_data            - head byte, 8'h00 when empty
//   empty, full, level - occupancy status
//   thresh_flag        - level at or above threshold
//   overrun            - sticky, a byte was dropped on full
//   timeout_flag       - idle timeout
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH_DEFAULT
) ();

    localparam int LW = $clog2(DEPTH) + 1;

    byte_t          rx_data;
    logic           rx_done;
    logic [15:0]    bit_period;
    logic           pop;
    logic           flush;
    logic           clr_overrun;
    byte_t          rd_data;
    logic           empty;
    logic           full;
    logic [LW-1:0]  level;
    logic           thresh_flag;
    logic           overrun;
    logic           timeout_flag;

    modport master (
        output rx_data, rx_done, bit_period, pop, flush, clr_overrun,
        input  rd_data, empty, full, level, thresh_flag, overrun, timeout_flag
    );

    modport slave (
        input  rx_data, rx_done, bit_period, pop, flush, clr_overrun,
        output rd_data, empty, full, level, thresh_flag, overrun, timeout_flag
    );

endinterface

// File: rtl/uart_rx_timeout.sv
// Idle timeout for the receive FIFO: a prescaler divides clk by bit_period
// to produce bit-time ticks, and a saturating bit counter counts ticks while
// the FIFO holds data and sees no activity. The flag rises on the tick that
// brings the count to TIMEOUT_BITS and holds until the next activity.
// Ports:
//   clk, nrst     - clock, synchronous active-low reset
//   bit_period_i  - clocks per bit; 0 holds the counters and blocks the flag
//   active_i      - FIFO not empty
//   event_i       - push, pop or flush request this cycle
//   timeout_o     - registered timeout flag
module uart_rx_timeout #(
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] bit_period_i,
    input  logic        active_i,
    input  logic        event_i,
    output logic        timeout_o
);

    localparam int CW = $clog2(TIMEOUT_BITS + 1);

    logic [15:0]   presc_q, presc_d;
    logic [CW-1:0] bits_q, bits_d;
    logic          flag_q, flag_d;

    // Next-state for prescaler, bit counter and flag.
    always_comb begin
        presc_d = presc_q;
        bits_d  = bits_q;
        flag_d  = flag_q;
        if (event_i || !active_i || (bit_period_i == 16'd0)) begin
            presc_d = 16'd0;
            bits_d  = {CW{1'b0}};
            if (event_i) begin
                flag_d = 1'b0;
            end else begin
                flag_d = flag_q;
            end
        end else if (presc_q >= (bit_period_i - 16'd1)) begin
            // One bit-time elapsed; >= tolerates bit_period shrinking mid-count.
            presc_d = 16'd0;
            if (bits_q < CW'(TIMEOUT_BITS)) begin
                bits_d = bits_q + CW'(1);
            end else begin
                bits_d = bits_q;
            end
            if (bits_q == CW'(TIMEOUT_BITS - 1)) begin
                flag_d = 1'b1;
            end else begin
                flag_d = flag_q;
            end
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            presc_q <= 16'd0;
            bits_q  <= {CW{1'b0}};
            flag_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            bits_q  <= bits_d;
            flag_q  <= flag_d;
        end
    end

    assign timeout_o = flag_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures each rx_done byte into a power-of-two buffer
// and presents the oldest byte first-word-fall-through to the bus side.
// Configuration macro: UART_RX_FIFO_TIMEOUT_EN enables the idle timeout
// (uart_rx_timeout); without it timeout_flag is tied low.
// Ports:
//   clk     - clock
//   nrst    - synchronous active-low reset; drops all contents
//   bus_if  - uart_rx_fifo_if slave modport (push/pop/flush in, status out)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = UART_FIFO_DEPTH_DEFAULT,
    parameter int THRESH       = UART_FIFO_THRESH_DEFAULT,
    parameter int TIMEOUT_BITS = UART_TIMEOUT_BITS_DEFAULT
) (
    input  logic           clk,
    input  logic           nrst,
    uart_rx_fifo_if.slave  bus_if
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    byte_t          mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           overrun_q, overrun_d;
    logic           empty_s, full_s;
    logic           push_s, pop_s, ovf_s;
    logic           timeout_s;

    assign empty_s = (level_q == {LW{1'b0}});
    assign full_s  = (level_q == LW'(DEPTH));

    // Accept/reject decisions and next-state for pointers, level and overrun.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ovf_s     = 1'b0;
        if (bus_if.flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            level_d  = {LW{1'b0}};
        end else begin
            pop_s  = bus_if.pop && !empty_s;
            // A pop on a full FIFO frees the slot the push lands in.
            push_s = bus_if.rx_done && (!full_s || pop_s);
            ovf_s  = bus_if.rx_done && full_s && !pop_s;
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        // Overflow set beats a same-cycle clear.
        if (ovf_s) begin
            overrun_d = 1'b1;
        end else if (bus_if.clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Pointer, level and overrun registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            level_q   <= {LW{1'b0}};
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    // Byte storage; contents are not reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= bus_if.rx_data;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    logic activity_s;
    assign activity_s = bus_if.rx_done || bus_if.pop || bus_if.flush;

    uart_rx_timeout #(
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) u_timeout (
        .clk          (clk),
        .nrst         (nrst),
        .bit_period_i (bus_if.bit_period),
        .active_i     (!empty_s),
        .event_i      (activity_s),
        .timeout_o    (timeout_s)
    );
`else
    logic unused_bit_period_s;
    assign unused_bit_period_s = ^bus_if.bit_period;
    assign timeout_s           = 1'b0;
`endif

    assign bus_if.rd_data      = empty_s ? 8'h00 : mem_q[rd_ptr_q];
    assign bus_if.empty        = empty_s;
    assign bus_if.full         = full_s;
    assign bus_if.level        = level_q;
    assign bus_if.thresh_flag  = (level_q >= LW'(THRESH));
    assign bus_if.overrun      = overrun_q;
    assign bus_if.timeout_flag = timeout_s;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH=16, THRESH=8, TIMEOUT_BITS=40).
// A queue-based reference model tracks contents and overrun; popped bytes are
// pushed to a scoreboard that a negedge monitor drains when the DUT consumes.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH  = 16;
    localparam int THRESH = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DEPTH        (DEPTH),
        .THRESH       (THRESH),
        .TIMEOUT_BITS (40)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;
    byte_t model_q[$];
    bit    m_ovr    = 1'b0;
    byte_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances at the edge.
    task automatic cycle(input bit d, input byte_t b, input bit p, input bit f, input bit c);
        bit pop_eff;
        bit push_eff;
        bit set_ovr;
        bus.rx_done     = d;
        bus.rx_data     = b;
        bus.pop         = p;
        bus.flush       = f;
        bus.clr_overrun = c;
        pop_eff  = p && !f && (model_q.size() > 0);
        push_eff = d && !f && ((model_q.size() < DEPTH) || pop_eff);
        set_ovr  = d && !f && (model_q.size() == DEPTH) && !pop_eff;
        if (pop_eff) exp_q.push_back(model_q[0]);
        @(posedge clk);
        if (f) model_q.delete();
        if (pop_eff) void'(model_q.pop_front());
        if (push_eff) model_q.push_back(b);
        if (set_ovr) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        #1;
        bus.rx_done     = 1'b0;
        bus.pop         = 1'b0;
        bus.flush       = 1'b0;
        bus.clr_overrun = 1'b0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        bus.rx_done = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_overrun = 1'b0;
        @(posedge clk);
        model_q.delete();
        exp_q.delete();
        m_ovr = 1'b0;
        #1;
        nrst = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: status vs model every cycle; popped bytes vs scoreboard.
    always @(negedge clk) begin
        if (mon_en && nrst) begin
            automatic int sz = model_q.size();
            chk("level", int'(bus.level), sz);
            chk("empty", int'(bus.empty), int'(sz == 0));
            chk("full", int'(bus.full), int'(sz == DEPTH));
            chk("thresh_flag", int'(bus.thresh_flag), int'(sz >= THRESH));
            chk("overrun", int'(bus.overrun), int'(m_ovr));
            chk("rd_data_head", int'(bus.rd_data), (sz > 0) ? int'(model_q[0]) : 0);
`ifndef UART_RX_FIFO_TIMEOUT_EN
            chk("timeout_off", int'(bus.timeout_flag), 0);
`endif
            if (bus.pop && !bus.empty && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underrun", 1, 0);
                end else begin
                    automatic byte_t e = exp_q.pop_front();
                    chk("pop_data", int'(bus.rd_data), int'(e));
                end
            end
        end
    end

    initial begin
        bus.rx_data = 8'h00; bus.bit_period = 16'd0;
        do_reset();
        do_reset();
        mon_en = 1'b1;
        #1;
        chk("reset_rd_data", int'(bus.rd_data), 0);
        chk("reset_empty", int'(bus.empty), 1);

        // Single byte fall-through and pop.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("a5_visible", int'(bus.rd_data), 'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("a5_popped_empty", int'(bus.empty), 1);

        // Fill, overflow, drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, byte_t'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", int'(bus.full), 1);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("overflow_sets_overrun", int'(bus.overrun), 1);
        drain();
        chk("drained_level", int'(bus.level), 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Full with simultaneous pop and push.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, byte_t'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("full_pushpop_level", int'(bus.level), DEPTH);
        chk("full_pushpop_no_ovr", int'(bus.overrun), 0);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("last_is_55", int'(bus.rd_data), 'h55);
        drain();

        // 20 bytes with interleaved pops across the wrap, pop on empty.
        for (int i = 0; i < 20; i++) cycle(1'b1, byte_t'(8'h40 + i), (i % 3) != 0, 1'b0, 1'b0);
        drain();
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pop_empty_level", int'(bus.level), 0);

        // Overrun survives flush; set beats clear.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, byte_t'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("level5", int'(bus.level), 5);
        cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        chk("flush_empty", int'(bus.empty), 1);
        chk("flush_keeps_ovr", int'(bus.overrun), 1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, byte_t'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        chk("set_beats_clr", int'(bus.overrun), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_overrun", int'(bus.overrun), 0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 99) < 45, byte_t'($urandom_range(0, 255)),
                  $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 5);
        end

        // Reset mid-traffic drops everything.
        for (int i = 0; i < 6; i++) cycle(1'b1, byte_t'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        do_reset();
        chk("midreset_empty", int'(bus.empty), 1);
        chk("midreset_rd_data", int'(bus.rd_data), 0);
        cycle(1'b1, 8'h9C, 1'b0, 1'b0, 1'b0);
        chk("post_reset_push", int'(bus.rd_data), 'h9C);
        drain();

`ifdef UART_RX_FIFO_TIMEOUT_EN
        bus.bit_period = 16'd4;
        cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 165; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (k == 159) chk("timeout_before", int'(bus.timeout_flag), 0);
            if (k == 160) chk("timeout_at_160", int'(bus.timeout_flag), 1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("timeout_cleared_by_pop", int'(bus.timeout_flag), 0);
        bus.bit_period = 16'd0;
        cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("timeout_bp0", int'(bus.timeout_flag), 0);
        drain();
`endif

        mon_en = 1'b0;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
